cmp_arbiter: RTL and testbench

CMP_ARBITER -- requirements
Module: cmp_arbiter

---
 rtl/cmp_pkg.sv | 16 +
 rtl/cmp_arbiter_cmp.sv | 25 ++
 rtl/cmp_arbiter.sv | 98 +++++++++
 tb/tb_cmp_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the arbitrated comparator block.
//   CMP_WIDTH : operand width of the shared comparator
//   state_t   : arbiter FSM states (IDLE, RESULT)
//   req_id_t  : requester index (0 or 1)
package cmp_pkg;

  localparam int unsigned CMP_WIDTH = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    RESULT = 1'b1
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/cmp_arbiter_cmp.sv
// Unsigned magnitude comparator, purely combinational.
// Ports:
//   a, b : operands (unsigned, WIDTH bits)
//   gt   : a > b
//   lt   : a < b
//   eq   : a == b
module cmp_arbiter_cmp
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = CMP_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  always_comb begin
    gt = (a > b);
    lt = (a < b);
    eq = (a == b);
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Two-requester round-robin arbiter in front of one shared unsigned
// comparator. An accepted operand pair is registered and its compare
// result is presented one cycle later, held until the consumer takes it.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   reqN_valid/a/b      : requester N operand pair pending (N = 0, 1)
//   reqN_ready          : requester N pair accepted this cycle
//   res_valid           : result present on res_* outputs
//   res_id              : requester that owns the result
//   res_gt/lt/eq        : a>b, a<b, a==b of the accepted pair
//   res_ready           : consumer takes the result this cycle
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int unsigned FIRST_GRANT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [CMP_WIDTH-1:0] req0_a,
  input  logic [CMP_WIDTH-1:0] req0_b,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [CMP_WIDTH-1:0] req1_a,
  input  logic [CMP_WIDTH-1:0] req1_b,
  output logic                 req1_ready,
  output logic                 res_valid,
  output logic                 res_id,
  output logic                 res_gt,
  output logic                 res_lt,
  output logic                 res_eq,
  input  logic                 res_ready
);

  state_t               state, state_next;
  req_id_t              last_grant, grant, id_q;
  logic [CMP_WIDTH-1:0] a_q, b_q;
  logic                 can_accept, accept;

  // Sole requester wins; under contention the one not served last wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    can_accept = 1'b0;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    // rst gates acceptance so no handshake completes in a reset cycle.
    can_accept = !rst && ((state == IDLE) || (state == RESULT && res_ready));
    accept     = can_accept && (req0_valid || req1_valid);
    req0_ready = can_accept && req0_valid && (grant == 1'b0);
    req1_ready = can_accept && req1_valid && (grant == 1'b1);
    unique case (state)
      IDLE:   if (accept) state_next = RESULT;
      RESULT: begin
        if (accept)         state_next = RESULT;
        else if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      last_grant <= (FIRST_GRANT == 0) ? 1'b1 : 1'b0;
    end else if (accept) begin
      a_q        <= grant ? req1_a : req0_a;
      b_q        <= grant ? req1_b : req0_b;
      id_q       <= grant;
      last_grant <= grant;
    end
  end

  cmp_arbiter_cmp #(.WIDTH(CMP_WIDTH)) u_cmp (
    .a  (a_q),
    .b  (b_q),
    .gt (res_gt),
    .lt (res_lt),
    .eq (res_eq)
  );

  assign res_valid = (state == RESULT);
  assign res_id    = id_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter (FIRST_GRANT = 0): directed
// scenarios followed by randomized traffic, all checked against a
// transaction-level reference model.
module tb_cmp_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        res_valid, res_id, res_gt, res_lt, res_eq;
  logic        res_ready;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference model: one optional pending result plus the last winner.
  bit          m_pend;
  bit          m_id;
  logic [15:0] m_a, m_b;
  bit          m_last;
  bit          m_after_rst;

  cmp_arbiter #(.FIRST_GRANT(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_gt     (res_gt),
    .res_lt     (res_lt),
    .res_eq     (res_eq),
    .res_ready  (res_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    bit can, acc, win;
    @(negedge clk);
    can = !rst && (!m_pend || res_ready);
    win = (req0_valid && req1_valid) ? !m_last : req1_valid;
    acc = can && (req0_valid || req1_valid);
    chk("req0_ready", req0_ready, acc && !win);
    chk("req1_ready", req1_ready, acc && win);
    chk("res_valid", res_valid, m_pend);
    if (m_pend) begin
      chk("res_id", res_id, m_id);
      chk("res_gt", res_gt, m_a > m_b);
      chk("res_lt", res_lt, m_a < m_b);
      chk("res_eq", res_eq, m_a == m_b);
    end else if (m_after_rst) begin
      chk("rst_id", res_id, 1'b0);
      chk("rst_gt", res_gt, 1'b0);
      chk("rst_lt", res_lt, 1'b0);
      chk("rst_eq", res_eq, 1'b1);
    end
    @(posedge clk);
    if (rst) begin
      m_pend = 0; m_id = 0; m_a = '0; m_b = '0; m_last = 1; m_after_rst = 1;
    end else begin
      if (acc) begin
        m_pend = 1; m_id = win; m_last = win; m_after_rst = 0;
        m_a = win ? req1_a : req0_a;
        m_b = win ? req1_b : req0_b;
      end else if (m_pend && res_ready) begin
        m_pend = 0;
      end
    end
    #1;
  endtask

  task automatic set_req(input bit v0, input logic [15:0] a0, input logic [15:0] b0,
                         input bit v1, input logic [15:0] a1, input logic [15:0] b1);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
  endtask

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    m_pend = 0; m_id = 0; m_a = '0; m_b = '0; m_last = 1; m_after_rst = 0;
    rst = 1; res_ready = 0;
    set_req(0, '0, '0, 0, '0, '0);
    #1;
    cycle(); cycle();

    // Single requester accepted in the same cycle, result one cycle later.
    rst = 0; res_ready = 1;
    set_req(1, 16'h1234, 16'h1233, 0, '0, '0);
    cycle();
    set_req(0, '0, '0, 0, '0, '0);
    chk("d030_valid", res_valid, 1'b1);
    chk("d030_id", res_id, 1'b0);
    chk("d030_gt", res_gt, 1'b1);
    cycle();

    // Contention from reset with res_ready held high: grants alternate.
    rst = 1; cycle(); rst = 0;
    res_ready = 1;
    set_req(1, 16'd5, 16'd9, 1, 16'd7, 16'd7);
    cycle();
    chk("d031_id0", res_id, 1'b0);
    chk("d031_lt", res_lt, 1'b1);
    cycle();
    chk("d031_id1", res_id, 1'b1);
    chk("d031_eq", res_eq, 1'b1);
    repeat (4) cycle();

    // Back-pressure for three cycles, then release.
    res_ready = 0;
    repeat (3) cycle();
    res_ready = 1;
    cycle();
    chk("d032_valid", res_valid, 1'b1);

    // Boundary operands through requester 0 alone.
    set_req(1, 16'hFFFF, 16'hFFFF, 0, '0, '0); cycle();
    chk("d033_eq", res_eq, 1'b1);
    set_req(1, 16'h0000, 16'hFFFF, 0, '0, '0); cycle();
    chk("d033_lt", res_lt, 1'b1);
    set_req(1, 16'hFFFF, 16'h0000, 0, '0, '0); cycle();
    chk("d033_gt", res_gt, 1'b1);
    set_req(0, '0, '0, 0, '0, '0); cycle();

    // Reset while a result is pending, then contention favours requester 0.
    res_ready = 0;
    set_req(0, '0, '0, 1, 16'd3, 16'd4); cycle();
    set_req(0, '0, '0, 0, '0, '0); cycle();
    rst = 1; cycle(); rst = 0;
    chk("d034_valid", res_valid, 1'b0);
    chk("d034_eq", res_eq, 1'b1);
    res_ready = 1;
    set_req(1, 16'd8, 16'd2, 1, 16'd2, 16'd8); cycle();
    chk("d034_id", res_id, 1'b0);
    set_req(0, '0, '0, 0, '0, '0); cycle();

    // One-cycle req1 pulse under back-pressure is never accepted.
    set_req(1, 16'd1, 16'd1, 0, '0, '0); cycle();
    res_ready = 0;
    set_req(0, '0, '0, 1, 16'd9, 16'd0); cycle();
    set_req(0, '0, '0, 0, '0, '0); cycle();
    chk("d035_id", res_id, 1'b0);
    res_ready = 1; cycle(); cycle();
    chk("d035_idle", res_valid, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      res_ready = ($urandom_range(0, 3) != 0);
      set_req($urandom_range(0, 1) == 1, rand_op(), rand_op(),
              $urandom_range(0, 1) == 1, rand_op(), rand_op());
      if ($urandom_range(0, 7) == 0) req0_b = req0_a;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
